// File: rtl/dti_s_if.sv
// rtl/dti_s_if.sv - DTI stream interface: data/valid/ready with producer and consumer views
interface dti_s_if #(
  parameter int DTI_DATA_WIDTH = 8
);
  logic [DTI_DATA_WIDTH-1:0] data;
  logic                      valid;
  logic                      ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_rr_arb.sv
// rtl/dti_rr_arb.sv - N-way round-robin lock-until-transfer arbiter onto one DTI stream, index prepended
// Optional one-entry output register: DTI_RR_ARB_OUT_REG_EN
module dti_rr_arb #(
  parameter  int N     = 4,
  parameter  int W_DIN = 16,
  localparam int IDXW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*W_DIN-1:0] din_data,
  input  logic [N-1:0]       din_valid,
  output logic [N-1:0]       din_ready,
  dti_s_if.producer          dout,
  output logic [IDXW-1:0]    grant_idx,
  output logic               busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [IDXW-1:0]   ptr;
  logic [W_DIN-1:0]  din_word [N];
  logic [W_DIN-1:0]  sel_word;
  logic [N-1:0]      grant_oh;
  logic [IDXW:0]     pick_idle;
  logic [IDXW:0]     pick_next;
  logic              ready_term;
  logic              xfer;

  // Returns {found, index} of the first set bit scanning start, start+1, ... modulo N.
  function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] req, input logic [IDXW-1:0] start);
    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
      idx = sum[IDXW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [IDXW-1:0] after(input logic [IDXW-1:0] w);
    return (w == IDXW'(N-1)) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) din_word[i] = din_data[i*W_DIN +: W_DIN];
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  assign sel_word  = din_word[grant_idx];
  // The requester being served is masked so it can never win twice in a row.
  assign pick_idle = rr_pick(din_valid, ptr);
  assign pick_next = rr_pick(din_valid & ~grant_oh, ptr);

  assign xfer      = (state == LOCK) && din_valid[grant_idx] && ready_term;
  assign din_ready = (!rst && state == LOCK && ready_term) ? grant_oh : '0;
  assign busy      = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[IDXW]) begin
            state     <= LOCK;
            grant_idx <= pick_idle[IDXW-1:0];
            ptr       <= after(pick_idle[IDXW-1:0]);
          end
        end
        LOCK: begin
          // A dropped valid without a transfer keeps the lock; only a transfer re-arbitrates.
          if (xfer) begin
            if (pick_next[IDXW]) begin
              grant_idx <= pick_next[IDXW-1:0];
              ptr       <= after(pick_next[IDXW-1:0]);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DTI_RR_ARB_OUT_REG_EN
  logic                  out_valid;
  logic [IDXW+W_DIN-1:0] out_data;

  // Slot accepts a new word when empty or when it is draining this cycle.
  assign ready_term = !out_valid || dout.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= {grant_idx, sel_word};
    end else if (dout.ready) begin
      out_valid <= 1'b0;
    end
  end

  assign dout.valid = out_valid && !rst;
  assign dout.data  = out_data;
`else
  assign ready_term = dout.ready;
  assign dout.valid = !rst && (state == LOCK) && din_valid[grant_idx];
  assign dout.data  = {grant_idx, sel_word};
`endif

endmodule

// File: tb/tb_dti_rr_arb.sv
// tb/tb_dti_rr_arb.sv - scoreboard bench for dti_rr_arb with a transfer-order reference model
module tb_dti_rr_arb;
  localparam int N     = 4;
  localparam int W_DIN = 16;
  localparam int IDXW  = $clog2(N);
  localparam int DW    = IDXW + W_DIN;
  localparam int MAXW  = 6;
`ifdef DTI_RR_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [N*W_DIN-1:0] din_data;
  logic [N-1:0]       din_valid;
  logic [N-1:0]       din_ready;
  logic [IDXW-1:0]    grant_idx;
  logic               busy;

  dti_s_if #(.DTI_DATA_WIDTH(DW)) dout_if ();

  dti_rr_arb #(.N(N), .W_DIN(W_DIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_data  (din_data),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout_if),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               failures = 0;
  logic [DW-1:0]    exp_q [$];
  logic [W_DIN-1:0] words [N][MAXW];
  int               len [N];
  int               head [N];
  int               m_ptr;
  int               ready_pct;
  logic             rst_val;
  logic [N-1:0]     hs_in;
  bit               vhist [$];
  int               hs_its [$];
  int               it;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: every queued word leaves in round-robin order over requesters that still
  // hold words, starting after the last one served; independent of backpressure timing.
  task automatic predict_round();
    int rem [N];
    int off [N];
    int g;
    bit found;
    for (int i = 0; i < N; i++) begin
      rem[i] = len[i] - head[i];
      off[i] = head[i];
    end
    for (int t = 0; t < N*MAXW; t++) begin
      found = 0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && rem[(m_ptr + k) % N] > 0) begin
          found = 1;
          g = (m_ptr + k) % N;
        end
      end
      if (found) begin
        exp_q.push_back({IDXW'(g), words[g][off[g]]});
        off[g]++;
        rem[g]--;
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (head[i] < len[i]) return 1;
    return 0;
  endfunction

  function automatic int first_one();
    for (int k = 0; k < vhist.size(); k++) if (vhist[k]) return k;
    return -1;
  endfunction

  task automatic clear_hist();
    it = 0;
    vhist.delete();
    hs_its.delete();
  endtask

  // One cycle: requesters advance on the previous handshake, then outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
    rst = rst_val;
    for (int i = 0; i < N; i++) begin
      if (hs_in[i]) head[i]++;
      din_valid[i] = (head[i] < len[i]);
      din_data[i*W_DIN +: W_DIN] = (head[i] < len[i]) ? words[i][head[i] % MAXW] : '0;
    end
    dout_if.ready = ($urandom_range(99, 0) < ready_pct);
    @(negedge clk);
    #1;
    hs_in = din_valid & din_ready;
    vhist.push_back(dout_if.valid);
    if (dout_if.valid && dout_if.ready) hs_its.push_back(it);
    it++;
  endtask

  task automatic run_round(input int budget, input string tag);
    int n;
    n = 0;
    while ((pending() || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, n < budget, 1'b1);
  endtask

  task automatic do_reset();
    check("drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    rst_val = 1'b1;
    ready_pct = 0;
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      head[i] = 0;
    end
    step();
    step();
    rst_val = 1'b0;
    m_ptr = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot0", $onehot0(din_ready), 1'b1);
`ifndef DTI_RR_ARB_OUT_REG_EN
      if (dout_if.valid) check("idx_field", dout_if.data[DW-1:W_DIN], grant_idx);
`endif
      if (dout_if.valid && dout_if.ready) begin
        check("sb_word_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("sb_word", dout_if.data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W_DIN-1:0] d1, d3;
    int n, f;
    rst = 1'b1;
    rst_val = 1'b1;
    din_valid = '0;
    din_data = '0;
    dout_if.ready = 1'b0;
    hs_in = '0;
    it = 0;

    // Reset with every requester valid, then full-rate round robin from index 0.
    ready_pct = 100;
    for (int i = 0; i < N; i++) begin
      len[i] = 3;
      head[i] = 0;
      for (int w = 0; w < MAXW; w++) words[i][w] = W_DIN'($urandom);
    end
    step();
    step();
    check("reset_dout_valid", dout_if.valid, 1'b0);
    check("reset_din_ready", din_ready, 0);
    check("reset_busy", busy, 1'b0);
    m_ptr = 0;
    predict_round();
    rst_val = 1'b0;
    clear_hist();
    run_round(300, "rr");
    check("first_valid_latency", first_one(), LAT);
    check("rr_hs_count", hs_its.size(), 12);
    check("rr_back_to_back", hs_its[$] - hs_its[0], 11);

    // Lone requester 2: alternating valid, one transfer every two cycles.
    do_reset();
    len[2] = 4;
    for (int w = 0; w < MAXW; w++) words[2][w] = W_DIN'($urandom);
    ready_pct = 100;
    predict_round();
    clear_hist();
    run_round(60, "single");
    f = first_one();
    check("single_first_valid", f, LAT);
    for (int k = 0; k < 7; k++) check("single_alt", vhist[(f + k) % vhist.size()], (k % 2) == 0);
    check("single_hs_count", hs_its.size(), 4);

    // Backpressure on requester 1 while requester 3 arrives.
    do_reset();
    d1 = W_DIN'($urandom);
    d3 = W_DIN'($urandom);
    words[1][0] = d1;
    len[1] = 1;
    ready_pct = 0;
    exp_q.push_back({IDXW'(1), d1});
    exp_q.push_back({IDXW'(3), d3});
    n = 0;
    while (!dout_if.valid && n < 6) begin
      step();
      n++;
    end
    check("bp_valid_seen", dout_if.valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        words[3][0] = d3;
        len[3] = 1;
      end
      step();
      check("bp_valid_held", dout_if.valid, 1'b1);
      check("bp_data_stable", dout_if.data, {IDXW'(1), d1});
`ifndef DTI_RR_ARB_OUT_REG_EN
      check("bp_grant_held", grant_idx, 1);
`endif
    end
    clear_hist();
    ready_pct = 100;
    run_round(50, "bp");
    check("bp_hs_count", hs_its.size(), 2);
    check("bp_back_to_back", hs_its[1] - hs_its[0], 1);

    // Reset while locked with ready low; arbitration restarts from index 0.
    do_reset();
    words[2][0] = W_DIN'($urandom);
    len[2] = 1;
    ready_pct = 0;
    n = 0;
    while (!busy && n < 6) begin
      step();
      n++;
    end
    check("ml_locked", busy, 1'b1);
    rst_val = 1'b1;
    step();
    check("ml_ready_in_rst", din_ready, 0);
    rst_val = 1'b0;
    words[3][0] = W_DIN'($urandom);
    len[3] = 1;
    ready_pct = 100;
    m_ptr = 0;
    predict_round();
    step();
    check("ml_idle_busy", busy, 1'b0);
    check("ml_no_ready", din_ready, 0);
    check("ml_no_valid", dout_if.valid, 1'b0);
    run_round(50, "ml");

    // Random bursts with random backpressure; pointer carries across rounds.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        head[i] = 0;
        len[i] = $urandom_range(MAXW, 0);
        for (int w = 0; w < MAXW; w++) words[i][w] = W_DIN'($urandom);
      end
      ready_pct = $urandom_range(100, 30);
      predict_round();
      run_round(400, "rand");
    end
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
